read_latency_probe: RTL and testbench
=====================================

READ_LATENCY_PROBE -- requirements
Module: read_latency_probe

Interface
REQ-001 SHALL have parameters, one per line:
- WIDTH, 32, checked data width in bits; one of 8, 16, 32, 64.
- MAX_OUTSTANDING, 8, maximum reads in flight; power of 2, 2..16.
- CNT_W, 32, width of the counters and results.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have these ports, one per line:
- clock  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- m_src_addr  in  64  base byte address.
- m_input_index  in  32  first element index.
- m_input_count  in  32  number of reads to issue.
- m_input_value  in  WIDTH  expected value of the first element.
- m_input_mode  in  1  0 = serial, 1 = pipelined.
- m_output_value  out  CNT_W  sum of all read latencies.
- m_output_min  out  CNT_W  minimum read latency.
- m_output_max  out  CNT_W  maximum read latency.
- m_output_errors  out  CNT_W  mismatch count plus spurious-response count.
- m_ready_out, m_valid_in, m_valid_out, m_ready_in  1 each  Avalon-ST handshake.
- src_readdata  in  512  read data.
- src_readdatavalid  in  1  read data valid.
- src_waitrequest  in  1  slave stall.
- src_writeack  in  1  unused.
- src_address  out  32  byte address.
- src_read  out  1  read request.
- src_write  out  1  tied 0.
- src_writedata  out  512  tied 0.
- src_byteenable  out  64  all ones.
- src_burstcount  out  5  tied 1.

Function
REQ-004 Start condition: start = m_ready_out & m_valid_in; it SHALL be accepted only in IDLE, and all inputs SHALL be captured on the start cycle.
REQ-005 The state machine SHALL have states IDLE, ISSUE, DRAIN, DONE with these transitions:
- IDLE -> ISSUE on start with count > 0.
- IDLE -> DONE on start with count = 0.
- ISSUE -> DRAIN after the last request is accepted.
- DRAIN -> DONE when the outstanding count is 0.
- DONE -> IDLE on m_valid_out & m_ready_in.
REQ-006 m_ready_out SHALL be 1 only in IDLE, and m_valid_out SHALL be 1 only in DONE.
REQ-007 Read i (0-based) SHALL use address m_src_addr + (WIDTH/8)*(m_input_index + i), truncated to 32 bits.
REQ-008 A request is accepted when src_read & ~src_waitrequest; src_read and src_address SHALL hold stable while src_waitrequest = 1.
REQ-009 Issue gating SHALL be:
- serial mode: src_read may assert only when outstanding = 0.
- pipelined mode: src_read may assert while outstanding < MAX_OUTSTANDING.
- src_read SHALL be reasserted back-to-back when allowed.
REQ-010 A cycle counter SHALL clear on start and increment every cycle.
REQ-011 On each accept the current counter value SHALL be pushed into a timestamp FIFO of depth MAX_OUTSTANDING.
REQ-012 On each src_readdatavalid the FIFO SHALL be popped, with latency = counter - timestamp (accept cycle to valid cycle, modulo 2^CNT_W).
REQ-013 Accept and valid in the same cycle SHALL push and pop together; outstanding is unchanged.
REQ-014 Latency accumulation:
- sum saturates at 2^CNT_W-1.
- min initialises to all ones; max initialises to 0.
- all three update on the valid cycle.
REQ-015 Response j SHALL be compared as src_readdata[WIDTH-1:0] against (m_input_value + j) mod 2^WIDTH; each mismatch SHALL increment the error count by 1.
REQ-016 A src_readdatavalid with outstanding = 0 SHALL NOT pop the FIFO and SHALL increment the error count.
REQ-017 Completion outputs:
- count = 0 gives value, min, max and errors all 0.
- results SHALL hold from entering DONE until the next start.
REQ-018 Responses arrive in order; no reordering logic SHALL exist.

Reset
REQ-019 On reset the block SHALL immediately enter IDLE with these output values:
- m_ready_out = 1.
- m_valid_out = 0.
- src_read = 0.
- src_address = 0.
- all result outputs = 0.
- FIFO and outstanding count = 0.
REQ-020 Reset during ISSUE or DRAIN SHALL abandon the run; responses arriving after reset deassertion count as spurious only if a new run is active, and are ignored in IDLE.
REQ-021 Start SHALL NOT be accepted in any cycle where reset is high.

Verification
REQ-022 Serial, count=1, index=3, base 0x1000, fixed 5-cycle slave latency, correct data -> address 0x100C, value=min=max=5, errors=0.
REQ-023 Pipelined, count=20, MAX_OUTSTANDING=8, slave latency 10 -> outstanding never exceeds 8, value=200, min=max=10, errors=0.
REQ-024 Pipelined, waitrequest high 3 cycles on request 2, data for element 7 corrupted -> address held stable through the stall, errors=1, min and max reflect accept-to-valid timing.
REQ-025 count=0 -> m_valid_out within 2 cycles of start, all results 0, no src_read asserted.
REQ-026 Reset asserted mid-DRAIN with 4 reads outstanding, then a new serial run of count=2 -> m_ready_out=1 immediately after reset, new run results correct, stale returns arriving in IDLE ignored.
REQ-027 m_ready_in held low for 10 cycles in DONE -> m_valid_out and results held stable throughout, and start is not accepted until the handshake completes.

Source files
------------

// File: rtl/read_latency_probe.sv
// Read latency probe: issues a run of Avalon-MM reads, timestamps each accept
// and reports latency sum/min/max plus data-mismatch and spurious-response errors.
module read_latency_probe #(
    parameter int WIDTH           = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [63:0]      m_src_addr,
    input  logic [31:0]      m_input_index,
    input  logic [31:0]      m_input_count,
    input  logic [WIDTH-1:0] m_input_value,
    input  logic             m_input_mode,
    output logic [CNT_W-1:0] m_output_value,
    output logic [CNT_W-1:0] m_output_min,
    output logic [CNT_W-1:0] m_output_max,
    output logic [CNT_W-1:0] m_output_errors,
    output logic             m_ready_out,
    input  logic             m_valid_in,
    output logic             m_valid_out,
    input  logic             m_ready_in,
    input  logic [511:0]     src_readdata,
    input  logic             src_readdatavalid,
    input  logic             src_waitrequest,
    input  logic             src_writeack,
    output logic [31:0]      src_address,
    output logic             src_read,
    output logic             src_write,
    output logic [511:0]     src_writedata,
    output logic [63:0]      src_byteenable,
    output logic [4:0]       src_burstcount
);

    localparam int PW    = $clog2(MAX_OUTSTANDING);
    localparam int OW    = PW + 1;
    localparam int BYTES = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    out_q;
    logic [PW-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0] ts_q [MAX_OUTSTANDING];
    logic [CNT_W-1:0] cnt_q, sum_q, min_q, max_q, err_q;
    logic [31:0]      addr_q, issued_q, total_q;
    logic [WIDTH-1:0] exp_q;
    logic             mode_q;

    logic             start, accept, active, rvalid, pop, gate;
    logic [CNT_W-1:0] lat;
    logic [CNT_W:0]   sum_ext;
    logic [31:0]      start_addr;
    logic             unused;

    assign unused = ^{src_writeack, m_src_addr[63:32], src_readdata[511:WIDTH]};

    assign m_ready_out = (state_q == IDLE);
    assign m_valid_out = (state_q == DONE);
    assign start       = m_ready_out & m_valid_in;
    assign active      = (state_q == ISSUE) | (state_q == DRAIN);

    // Serial mode waits for the previous response before the next request.
    assign gate     = mode_q ? (out_q < OW'(MAX_OUTSTANDING)) : (out_q == '0);
    assign src_read = (state_q == ISSUE) & gate;
    assign accept   = src_read & ~src_waitrequest;
    assign rvalid   = src_readdatavalid & active;
    assign pop      = rvalid & (out_q != '0);

    assign lat        = cnt_q - ts_q[rd_q];
    assign sum_ext    = {1'b0, sum_q} + {1'b0, lat};
    assign start_addr = m_src_addr[31:0] + 32'(BYTES) * m_input_index;

    assign src_address     = addr_q;
    assign src_write       = 1'b0;
    assign src_writedata   = '0;
    assign src_byteenable  = '1;
    assign src_burstcount  = 5'd1;
    assign m_output_value  = sum_q;
    assign m_output_min    = min_q;
    assign m_output_max    = max_q;
    assign m_output_errors = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (m_input_count == '0) ? DONE : ISSUE;
            ISSUE: if (accept && issued_q == total_q - 32'd1) state_d = DRAIN;
            DRAIN: if (out_q == '0) state_d = DONE;
            DONE:  if (m_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            err_q    <= '0;
            addr_q   <= '0;
            issued_q <= '0;
            total_q  <= '0;
            exp_q    <= '0;
            mode_q   <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) ts_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (start) begin
                cnt_q    <= '0;
                out_q    <= '0;
                wr_q     <= '0;
                rd_q     <= '0;
                sum_q    <= '0;
                max_q    <= '0;
                err_q    <= '0;
                min_q    <= (m_input_count == '0) ? '0 : '1;
                addr_q   <= start_addr;
                issued_q <= '0;
                total_q  <= m_input_count;
                exp_q    <= m_input_value;
                mode_q   <= m_input_mode;
            end else begin
                if (accept) begin
                    ts_q[wr_q] <= cnt_q;
                    wr_q       <= wr_q + 1'b1;
                    addr_q     <= addr_q + 32'(BYTES);
                    issued_q   <= issued_q + 32'd1;
                end
                if (pop) begin
                    rd_q  <= rd_q + 1'b1;
                    exp_q <= exp_q + 1'b1;
                    sum_q <= sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
                    if (lat < min_q) min_q <= lat;
                    if (lat > max_q) max_q <= lat;
                end
                // A response with nothing outstanding is spurious.
                if (rvalid && (out_q == '0 || src_readdata[WIDTH-1:0] != exp_q))
                    err_q <= err_q + CNT_W'(1);
                if (accept && !pop)
                    out_q <= out_q + 1'b1;
                else if (pop && !accept)
                    out_q <= out_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_read_latency_probe.sv
// Directed bench for read_latency_probe with a fixed-latency slave model
// and a scoreboard of expected run results.
module tb_read_latency_probe;

    localparam int W  = 32;
    localparam int MO = 8;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [63:0]   m_src_addr;
    logic [31:0]   m_input_index, m_input_count;
    logic [W-1:0]  m_input_value;
    logic          m_input_mode;
    logic [CW-1:0] m_output_value, m_output_min, m_output_max, m_output_errors;
    logic          m_ready_out, m_valid_in, m_valid_out, m_ready_in;
    logic [511:0]  src_readdata;
    logic          src_readdatavalid, src_waitrequest, src_writeack;
    logic [31:0]   src_address;
    logic          src_read, src_write;
    logic [511:0]  src_writedata;
    logic [63:0]   src_byteenable;
    logic [4:0]    src_burstcount;

    always #5 clock = ~clock;

    read_latency_probe #(.WIDTH(W), .MAX_OUTSTANDING(MO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .m_src_addr(m_src_addr), .m_input_index(m_input_index),
        .m_input_count(m_input_count), .m_input_value(m_input_value),
        .m_input_mode(m_input_mode),
        .m_output_value(m_output_value), .m_output_min(m_output_min),
        .m_output_max(m_output_max), .m_output_errors(m_output_errors),
        .m_ready_out(m_ready_out), .m_valid_in(m_valid_in),
        .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
        .src_readdata(src_readdata), .src_readdatavalid(src_readdatavalid),
        .src_waitrequest(src_waitrequest), .src_writeack(src_writeack),
        .src_address(src_address), .src_read(src_read), .src_write(src_write),
        .src_writedata(src_writedata), .src_byteenable(src_byteenable),
        .src_burstcount(src_burstcount)
    );

    typedef struct {
        logic [31:0] value;
        logic [31:0] min;
        logic [31:0] max;
        logic [31:0] err;
    } res_t;

    typedef struct {
        longint      due;
        logic [31:0] data;
        int          epoch;
    } rsp_t;

    res_t exp_q[$];
    rsp_t sq[$];

    int tests = 0;
    int fails = 0;

    logic [31:0] cfg_base, cfg_idx, cfg_seed;
    int          cfg_L = 1;
    int          cfg_stall_idx = -1;
    int          cfg_stall_len = 0;
    int          cfg_corrupt = -1;

    longint      ecount = 0;
    int          epoch = 0;
    int          rdv_epoch = 0;
    int          acc_cnt = 0;
    int          stall_left = 0;
    int          stall_edges = 0;
    int          max_out = 0;
    int          addr_bad = 0;
    int          read_seen = 0;
    logic [31:0] first_addr = '0;

    // Slave: accepts requests, answers each exactly cfg_L edges after accept.
    initial begin
        int          pre;
        logic [31:0] ea, d;
        src_readdatavalid = 1'b0;
        src_waitrequest   = 1'b0;
        src_readdata      = '0;
        forever begin
            @(posedge clock);
            ecount++;
            if (m_ready_out && m_valid_in && !reset) begin
                epoch++;
                acc_cnt     = 0;
                stall_left  = cfg_stall_len;
                stall_edges = 0;
                max_out     = 0;
                addr_bad    = 0;
                read_seen   = 0;
                first_addr  = '0;
            end else if (src_read) begin
                read_seen = 1;
                ea = cfg_base + 32'd4 * (cfg_idx + 32'(acc_cnt));
                if (src_address !== ea) addr_bad++;
                if (src_waitrequest) begin
                    stall_edges++;
                    if (stall_left > 0) stall_left--;
                end else begin
                    pre = 0;
                    foreach (sq[i]) if (sq[i].epoch == epoch) pre++;
                    if (src_readdatavalid && rdv_epoch == epoch) pre++;
                    if (pre + 1 > max_out) max_out = pre + 1;
                    if (acc_cnt == 0) first_addr = src_address;
                    d = cfg_seed + (src_address >> 2);
                    if (acc_cnt == cfg_corrupt) d = d ^ 32'h1;
                    sq.push_back('{ecount + longint'(cfg_L), d, epoch});
                    acc_cnt++;
                end
            end
            src_waitrequest <= (acc_cnt == cfg_stall_idx) && (stall_left > 0);
            if (sq.size() > 0 && sq[0].due <= ecount + 1) begin
                src_readdatavalid <= 1'b1;
                src_readdata      <= {480'b0, sq[0].data};
                rdv_epoch         <= sq[0].epoch;
                void'(sq.pop_front());
            end else begin
                src_readdatavalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic mode, input logic [31:0] base, input logic [31:0] idx,
                             input logic [31:0] cnt, input logic [31:0] seed, input int lat,
                             input int sidx, input int slen, input int corr);
        chk("start_ready", {63'b0, m_ready_out}, 64'd1);
        cfg_base      = base;
        cfg_idx       = idx;
        cfg_seed      = seed;
        cfg_L         = lat;
        cfg_stall_idx = sidx;
        cfg_stall_len = slen;
        cfg_corrupt   = corr;
        m_src_addr    = {32'h0, base};
        m_input_index = idx;
        m_input_count = cnt;
        m_input_value = seed + (base >> 2) + idx;
        m_input_mode  = mode;
        m_valid_in    = 1'b1;
        @(negedge clock);
        m_valid_in    = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int bound);
        int   n;
        res_t r;
        n = 0;
        while (!m_valid_out && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk({tag, ".done"}, {63'b0, m_valid_out}, 64'd1);
        r = exp_q.pop_front();
        chk({tag, ".value"}, {32'b0, m_output_value}, {32'b0, r.value});
        chk({tag, ".min"}, {32'b0, m_output_min}, {32'b0, r.min});
        chk({tag, ".max"}, {32'b0, m_output_max}, {32'b0, r.max});
        chk({tag, ".errors"}, {32'b0, m_output_errors}, {32'b0, r.err});
        if (m_ready_in) begin
            @(negedge clock);
            chk({tag, ".released"}, {63'b0, m_valid_out}, 64'd0);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        m_src_addr    = '0;
        m_input_index = '0;
        m_input_count = '0;
        m_input_value = '0;
        m_input_mode  = 1'b0;
        m_valid_in    = 1'b0;
        m_ready_in    = 1'b1;
        src_writeack  = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst.ready", {63'b0, m_ready_out}, 64'd1);
        chk("rst.valid", {63'b0, m_valid_out}, 64'd0);
        chk("rst.read", {63'b0, src_read}, 64'd0);
        chk("rst.addr", {32'b0, src_address}, 64'd0);
        chk("rst.value", {32'b0, m_output_value}, 64'd0);
        chk("rst.errors", {32'b0, m_output_errors}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        exp_q.push_back('{32'd5, 32'd5, 32'd5, 32'd0});
        start_run(1'b0, 32'h1000, 32'd3, 32'd1, 32'h100, 5, -1, 0, -1);
        finish_run("serial1", 60);
        chk("serial1.addr", {32'b0, first_addr}, 64'h100C);
        chk("serial1.accepts", 64'(acc_cnt), 64'd1);
        chk("serial1.addr_track", 64'(addr_bad), 64'd0);

        exp_q.push_back('{32'd200, 32'd10, 32'd10, 32'd0});
        start_run(1'b1, 32'h2000, 32'd0, 32'd20, 32'h55, 10, -1, 0, -1);
        finish_run("pipe20", 400);
        chk("pipe20.max_outstanding", 64'(max_out), 64'd8);
        chk("pipe20.accepts", 64'(acc_cnt), 64'd20);
        chk("pipe20.addr_track", 64'(addr_bad), 64'd0);

        exp_q.push_back('{32'd60, 32'd6, 32'd6, 32'd1});
        start_run(1'b1, 32'h3000, 32'd5, 32'd10, 32'hA0, 6, 2, 3, 7);
        finish_run("stall", 200);
        chk("stall.edges", 64'(stall_edges), 64'd3);
        chk("stall.addr_held", 64'(addr_bad), 64'd0);

        exp_q.push_back('{32'd0, 32'd0, 32'd0, 32'd0});
        start_run(1'b1, 32'h7000, 32'd0, 32'd0, 32'h1, 3, -1, 0, -1);
        finish_run("count0", 2);
        chk("count0.no_read", 64'(read_seen), 64'd0);

        m_ready_in = 1'b0;
        exp_q.push_back('{32'd6, 32'd2, 32'd2, 32'd0});
        start_run(1'b0, 32'h4000, 32'd1, 32'd3, 32'h9, 2, -1, 0, -1);
        finish_run("hold", 100);
        m_valid_in    = 1'b1;
        m_input_count = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold.valid", {63'b0, m_valid_out}, 64'd1);
            chk("hold.no_start", {63'b0, m_ready_out}, 64'd0);
            chk("hold.value", {32'b0, m_output_value}, 64'd6);
        end
        m_valid_in = 1'b0;
        m_ready_in = 1'b1;
        @(negedge clock);
        chk("hold.released", {63'b0, m_valid_out}, 64'd0);
        chk("hold.idle", {63'b0, m_ready_out}, 64'd1);

        start_run(1'b1, 32'h5000, 32'd0, 32'd4, 32'h3, 30, -1, 0, -1);
        repeat (8) @(negedge clock);
        chk("abort.busy", {63'b0, m_ready_out}, 64'd0);
        reset = 1'b1;
        #1;
        chk("abort.ready", {63'b0, m_ready_out}, 64'd1);
        chk("abort.read", {63'b0, src_read}, 64'd0);
        chk("abort.value", {32'b0, m_output_value}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("abort.stale_idle", {63'b0, m_ready_out}, 64'd1);
        chk("abort.stale_errors", {32'b0, m_output_errors}, 64'd0);
        exp_q.push_back('{32'd10, 32'd5, 32'd5, 32'd0});
        start_run(1'b0, 32'h6000, 32'd2, 32'd2, 32'h77, 5, -1, 0, -1);
        finish_run("after_abort", 100);
        chk("after_abort.accepts", 64'(acc_cnt), 64'd2);
        chk("after_abort.serial", 64'(max_out), 64'd1);
        chk("after_abort.addr_track", 64'(addr_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
